bus_arbiter_rr: RTL and testbench

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_arbiter_rr.sv | 135 +++++++++++++
 tb/tb_bus_arbiter_rr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Three-requester round-robin bus arbiter with registered one-hot grant, lock/hready-gated release
// and a one-cycle handover gap. Optional grant-hold timeout is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
    parameter int MAX_HOLD = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] done,
    input  logic       lock,
    input  logic       hready,
    output logic [2:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] state_dbg
);

    // Handshake: req is a level held by each requester until served; gnt is registered and
    // one-hot, rising one cycle after req is sampled; done is a one-cycle end-of-transfer pulse
    // that only counts from the current owner; release needs hready=1 and lock=0 that cycle.

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GRANT    = 2'd1;
    localparam logic [1:0] HANDOVER = 2'd2;

    logic [1:0] state;
    logic [1:0] ptr;
    logic       pending;
    logic       owner_req;
    logic       owner_done;
    logic       rel_ok;
    logic       rel_normal;
    logic       force_rel;
    logic       release_now;
    logic       arb_start;
    logic [1:0] win_idx;

    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        a = p;
        b = (a == 2'd2) ? 2'd0 : a + 2'd1;
        c = (b == 2'd2) ? 2'd0 : b + 2'd1;
        if (r[a])      return a;
        else if (r[b]) return b;
        else           return c;
    endfunction

    always_comb begin
        owner_req   = |(req & gnt);
        owner_done  = |(done & gnt);
        rel_ok      = hready & ~lock;
        rel_normal  = (owner_done | pending | ~owner_req) & rel_ok;
        release_now = (state == GRANT) & (rel_normal | force_rel);
        arb_start   = ((state == IDLE) || (state == HANDOVER)) && (req != 3'b000);
        win_idx     = rr_pick(req, ptr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 3'b000;
            owner   <= 2'd3;
            ptr     <= 2'd0;
            pending <= 1'b0;
        end else begin
            case (state)
                IDLE, HANDOVER: begin
                    // HANDOVER is the dead cycle; arbitration for the next owner happens on its edge.
                    if (arb_start) begin
                        state   <= GRANT;
                        gnt     <= 3'b001 << win_idx;
                        owner   <= win_idx;
                        pending <= 1'b0;
                    end else begin
                        state <= IDLE;
                        gnt   <= 3'b000;
                        owner <= 2'd3;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state   <= HANDOVER;
                        gnt     <= 3'b000;
                        owner   <= 2'd3;
                        ptr     <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
                        pending <= 1'b0;
                    end else if (owner_done) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 3'b000;
                    owner <= 2'd3;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt;
    logic          timeout_q;

    // Counter saturates at the limit so a locked owner is released as soon as lock drops.
    assign force_rel = (hold_cnt == HOLD_LAST) & rel_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (arb_start)
                hold_cnt <= '0;
            else if ((state == GRANT) && (hold_cnt != HOLD_LAST))
                hold_cnt <= hold_cnt + 1'b1;
            timeout_q <= (state == GRANT) & force_rel & ~rel_normal;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign busy      = (state == GRANT) || (state == HANDOVER);
    assign state_dbg = state;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a vector table of stateful steps plus hand-written
// sequences for round-robin rotation and (when ARB_TIMEOUT_EN is defined) the hold timeout.
module tb_bus_arbiter_rr;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] done;
        logic       lock;
        logic       hready;
        logic [2:0] exp_gnt;
        logic [1:0] exp_owner;
        logic       exp_busy;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] done;
    logic       lock;
    logic       hready;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];

    bus_arbiter_rr #(.MAX_HOLD(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .lock     (lock),
        .hready   (hready),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .timeout  (timeout),
        .state_dbg(state_dbg)
    );

    // Clock and time guard
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic [2:0] rq, input logic [2:0] d,
                           input logic lk, input logic hr, input logic [2:0] g,
                           input logic [1:0] o, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d; v.lock = lk; v.hready = hr;
        v.exp_gnt = g; v.exp_owner = o; v.exp_busy = b;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset, then round-robin through all three requesters with a 4-cycle tenure each.
    task automatic run_rr_seq;
        logic [2:0] exp_g;
        int held;
        int zeros;
        bit seen_first;
        rst = 1'b1; req = 3'b000; done = 3'b000; lock = 1'b0; hready = 1'b1;
        tick();
        rst = 1'b0; req = 3'b111;
        exp_q = '{3'b001, 3'b010, 3'b100, 3'b001};
        held = 0; zeros = 0; seen_first = 1'b0;
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            tick();
            done = 3'b000;
            if (gnt != 3'b000) begin
                if (held == 0) begin
                    exp_g = exp_q.pop_front();
                    check("rr_order", 8'(gnt), 8'(exp_g));
                    if (seen_first) check("rr_gap", 8'(zeros), 8'd1);
                    seen_first = 1'b1;
                end
                held++;
                zeros = 0;
                if (held == 4) done = gnt;
            end else begin
                zeros++;
                held = 0;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_budget: got %0d grants pending expected 0", exp_q.size());
        end
        req = 3'b000; done = 3'b000;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic run_timeout_seq;
        int cnt;
        rst = 1'b1; req = 3'b000; done = 3'b000; lock = 1'b0; hready = 1'b1;
        tick();
        rst = 1'b0; req = 3'b001;
        cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (gnt == 3'b001) cnt++;
            else break;
        end
        check("to_hold_cycles", 8'(cnt), 8'd8);
        check("to_gnt_drop", 8'(gnt), 8'h0);
        check("to_pulse", 8'(timeout), 8'h1);
        req = 3'b011;
        tick();
        check("to_next_gnt", 8'(gnt), 8'h2);
        check("to_pulse_end", 8'(timeout), 8'h0);
    endtask
`endif

    initial begin
        rst = 1'b1; req = 3'b000; done = 3'b000; lock = 1'b0; hready = 1'b1;

        //      rst  req     done    lk    hr    gnt     own   busy
        add_vec(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0);
        add_vec(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0);
        add_vec(1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b111, 3'b010, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b111, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b1);
        add_vec(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1);
        add_vec(1'b0, 3'b111, 3'b100, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1);
        add_vec(1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1);
        add_vec(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b1);
        add_vec(1'b0, 3'b011, 3'b000, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1);
        add_vec(1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b1);
        add_vec(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0);
        add_vec(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0);
        add_vec(1'b0, 3'b100, 3'b000, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1);
        add_vec(1'b1, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0);
        add_vec(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1);
        add_vec(1'b0, 3'b111, 3'b001, 1'b0, 1'b1, 3'b000, 2'd3, 1'b1);
        add_vec(1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b111, 3'b100, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b101, 3'b000, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1);
        add_vec(1'b0, 3'b101, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b1);
        add_vec(1'b0, 3'b001, 3'b000, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; done = vecs[i].done;
            lock = vecs[i].lock; hready = vecs[i].hready;
            tick();
            check($sformatf("vec%0d_gnt", i), 8'(gnt), 8'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_owner", i), 8'(owner), 8'(vecs[i].exp_owner));
            check($sformatf("vec%0d_busy", i), 8'(busy), 8'(vecs[i].exp_busy));
            check($sformatf("vec%0d_timeout", i), 8'(timeout), 8'h0);
        end

        run_rr_seq();
`ifdef ARB_TIMEOUT_EN
        run_timeout_seq();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
